// File: rtl/i2s_wfifo_sequencer_pkg.sv
// i2s_wfifo_sequencer_pkg: sequencer state encoding and round-robin FIFO pick
package i2s_wfifo_sequencer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FILL, S_RELEASE} state_e;
  function automatic logic rr_pick(input logic [1:0] ready, input logic last);
    return (&ready) ? ~last : ready[1];
  endfunction
endpackage

// File: rtl/i2s_wfifo_sequencer.sv
// i2s_wfifo_sequencer: grants ping-pong write FIFOs in turn, streams words into them, counts starvation
module i2s_wfifo_sequencer
  import i2s_wfifo_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  src_flush_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic [SIZE_WIDTH-1:0] wfifo_size_i,
  input  logic [1:0]            wfifo_ready_i,
  output logic [1:0]            wfifo_activate_o,
  output logic                  wfifo_strobe_o,
  output logic [DATA_WIDTH-1:0] wfifo_data_o,
  output logic                  busy_o,
  output logic                  active_sel_o,
  output logic [SIZE_WIDTH-1:0] fill_count_o,
  output logic [CNT_WIDTH-1:0]  starve_count_o,
  output logic                  config_err_o
);
  state_e                state_q, state_d;
  logic [1:0]            act_q;
  logic                  sel_q, last_sel_q, primed_q, strobe_q, starve_cond_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SIZE_WIDTH-1:0] fill_q, size_q;
  logic [CNT_WIDTH-1:0]  starve_q;
  logic                  start, accept, full, pick, starve_cond;
  assign start       = enable_i && (wfifo_size_i != '0) && (wfifo_ready_i != 2'b00);
  assign full        = fill_q == size_q;
  assign accept      = src_valid_i && src_ready_o;
  assign pick        = rr_pick(wfifo_ready_i, last_sel_q);
  assign starve_cond = enable_i && primed_q && (&wfifo_ready_i);
  always_ff @(posedge clk_i) state_q <= !rst_ni ? S_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = start ? S_GRANT : S_IDLE;
      S_GRANT: state_d = S_FILL;
      S_FILL:  state_d = (full || !enable_i || (src_flush_i && fill_q != '0)) ? S_RELEASE : S_FILL;
      default: state_d = S_IDLE;
    endcase
  end
  // Ready depends only on registers so the upstream never sees a comb path from its own valid.
  always_comb begin
    src_ready_o      = (state_q == S_FILL) && (fill_q < size_q);
    busy_o           = state_q != S_IDLE;
    config_err_o     = enable_i && (wfifo_size_i == '0);
    wfifo_activate_o = act_q;
    wfifo_strobe_o   = strobe_q;
    wfifo_data_o     = data_q;
    active_sel_o     = sel_q;
    fill_count_o     = fill_q;
    starve_count_o   = starve_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      act_q      <= 2'b00;
      sel_q      <= 1'b0;
      last_sel_q <= 1'b1;
      primed_q   <= 1'b0;
      strobe_q   <= 1'b0;
      data_q     <= '0;
      fill_q     <= '0;
      size_q     <= '0;
    end else begin
      strobe_q <= accept;
      if (accept) begin
        data_q <= src_data_i;
        fill_q <= fill_q + SIZE_WIDTH'(1);
      end
      if (state_q == S_IDLE && start) begin
        act_q  <= {pick, ~pick};
        sel_q  <= pick;
        fill_q <= '0;
        size_q <= wfifo_size_i;
      end
      if (state_q == S_RELEASE) begin
        act_q      <= 2'b00;
        last_sel_q <= sel_q;
        primed_q   <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cond_q <= 1'b0;
      starve_q      <= '0;
    end else begin
      starve_cond_q <= starve_cond;
      if (starve_cond && !starve_cond_q && !(&starve_q)) starve_q <= starve_q + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_i2s_wfifo_sequencer.sv
// tb_i2s_wfifo_sequencer: directed steps with a data scoreboard on the write strobe
module tb_i2s_wfifo_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, enable = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [31:0] src_data = '0;
  logic [23:0] size = 24'd4;
  logic [1:0]  ready = 2'b00;
  logic        src_ready, strobe, busy, active_sel, config_err;
  logic [1:0]  act;
  logic [31:0] wdata, starve;
  logic [23:0] fill;
  int          checks = 0, errors = 0, strobes = 0, s0;
  logic [31:0] exp_q[$];
  i2s_wfifo_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .src_flush_i(flush),
    .src_valid_i(valid), .src_ready_o(src_ready), .src_data_i(src_data),
    .wfifo_size_i(size), .wfifo_ready_i(ready), .wfifo_activate_o(act),
    .wfifo_strobe_o(strobe), .wfifo_data_o(wdata), .busy_o(busy),
    .active_sel_o(active_sel), .fill_count_o(fill), .starve_count_o(starve),
    .config_err_o(config_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic send(input logic [31:0] d);
    int n = 0;
    valid = 1'b1;
    src_data = d;
    while (!src_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", src_ready, 1);
    if (src_ready) exp_q.push_back(d);
    tick();
    valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (act === 2'b11) check("act_onehot", act, 2'b01);
    if (strobe === 1'b1) begin
      strobes++;
      check("act_during_strobe", act == 2'b00, 0);
      if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
      else check("strobe_data", wdata, exp_q.pop_front());
    end
  end
  initial begin
    repeat (2) tick();
    check("rst_act", act, 0);
    check("rst_strobe", strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_fill", fill, 0);
    check("rst_starve", starve, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_sel", active_sel, 0);
    check("rst_data", wdata, 0);
    rst_n = 1'b1;
    // 1: both ready, four back-to-back words, then round-robin
    size = 24'd4; ready = 2'b11; enable = 1'b1;
    tick();
    check("t1_grant_act", act, 2'b01);
    check("t1_grant_ready", src_ready, 0);
    check("t1_busy", busy, 1);
    s0 = strobes;
    send(32'hA000_0001); send(32'hA000_0002); send(32'hA000_0003); send(32'hA000_0004);
    check("t1_fill_full", fill, 4);
    check("t1_ready_full", src_ready, 0);
    check("t1_act_t3", act, 2'b01);
    tick();
    check("t1_act_t4", act, 2'b01);
    tick();
    check("t1_act_low", act, 2'b00);
    check("t1_strobes", strobes - s0, 4);
    tick();
    check("t1_rr_act", act, 2'b10);
    check("t1_rr_sel", active_sel, 1);
    check("t1_starve", starve, 1);
    enable = 1'b0;
    repeat (3) tick();
    check("t1_drain_act", act, 0);
    check("t1_drain_busy", busy, 0);
    // 2: only FIFO1 ready, gaps in valid
    ready = 2'b10; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(32'hB000_0000 + 32'(k));
      check("t2_fill", fill, 24'(k + 1));
      check("t2_strobe", strobe, 1);
      check("t2_act", act, 2'b10);
      if (k < 3) begin
        tick();
        check("t2_gap_strobe", strobe, 0);
        tick();
      end
    end
    enable = 1'b0;
    repeat (2) tick();
    check("t2_release_act", act, 0);
    // 3: flush at count 0 ignored, flush after three words releases
    size = 24'd8; ready = 2'b01; enable = 1'b1;
    repeat (2) tick();
    check("t3_fill_ready", src_ready, 1);
    flush = 1'b1;
    tick();
    check("t3_flush0_busy", busy, 1);
    check("t3_flush0_act", act, 2'b01);
    check("t3_flush0_ready", src_ready, 1);
    flush = 1'b0;
    send(32'hC000_0001); send(32'hC000_0002); send(32'hC000_0003);
    check("t3_fill3", fill, 3);
    flush = 1'b1;
    tick();
    check("t3_rel_fill", fill, 3);
    check("t3_rel_ready", src_ready, 0);
    check("t3_rel_act", act, 2'b01);
    flush = 1'b0; enable = 1'b0;
    tick();
    check("t3_idle_act", act, 0);
    check("t3_idle_busy", busy, 0);
    // 4: enable dropped after two of four words
    size = 24'd4; enable = 1'b1;
    send(32'hD000_0001); send(32'hD000_0002);
    enable = 1'b0;
    tick();
    check("t4_rel_fill", fill, 2);
    check("t4_rel_busy", busy, 1);
    tick();
    check("t4_idle_act", act, 0);
    repeat (3) tick();
    check("t4_stay_idle", busy, 0);
    // 4b: reset in the middle of FILL
    ready = 2'b11; enable = 1'b1;
    send(32'hD100_0001);
    check("t4_pre_rst_act", act, 2'b10);
    rst_n = 1'b0;
    tick();
    check("t4_rst_act", act, 0);
    check("t4_rst_fill", fill, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_sel", active_sel, 0);
    check("t4_rst_starve", starve, 0);
    rst_n = 1'b1;
    tick();
    check("t4_resume_act", act, 2'b01);
    enable = 1'b0;
    repeat (4) tick();
    check("t4_drain_act", act, 0);
    // 5: starvation counting
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; enable = 1'b1; ready = 2'b11;
    repeat (5) tick();
    check("t5_unprimed", starve, 0);
    ready = 2'b01;
    send(32'hE000_0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    ready = 2'b11;
    tick();
    check("t5_starve1", starve, 1);
    ready = 2'b01;
    tick();
    ready = 2'b11;
    tick();
    check("t5_starve2", starve, 2);
    repeat (100) tick();
    check("t5_hold", starve, 2);
    enable = 1'b0;
    repeat (4) tick();
    ready = 2'b01; enable = 1'b1;
    tick();
    ready = 2'b11; enable = 1'b0;
    repeat (3) tick();
    check("t5_disabled", starve, 2);
    repeat (4) tick();
    // 6: zero size is a configuration error
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; size = '0; ready = 2'b11; enable = 1'b1;
    #1;
    check("t6_cfg_err", config_err, 1);
    repeat (3) tick();
    check("t6_act", act, 0);
    check("t6_ready", src_ready, 0);
    check("t6_busy", busy, 0);
    size = 24'd4;
    #1;
    check("t6_cfg_clear", config_err, 0);
    enable = 1'b0;
    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
